// File: rtl/light_sequencer_pkg.sv
// Shared types and constants for the traffic light sequencer.
// Optional walk phase is enabled with `define LIGHT_SEQ_WALK_EN.
package light_sequencer_pkg;

   localparam int TW = 7;

   localparam logic [2:0] RED    = 3'b100;
   localparam logic [2:0] YELLOW = 3'b010;
   localparam logic [2:0] GREEN  = 3'b001;

   typedef enum logic [2:0] {
      S_INIT,
      S_MAIN_GREEN,
      S_MAIN_YELLOW,
      S_ALL_RED_A,
      S_WALK,
      S_SIDE_GREEN,
      S_SIDE_YELLOW,
      S_ALL_RED_B
   } state_t;

   // A zero duration would never let the timer report a fresh expiry.
   function automatic logic [TW-1:0] clamp_dur(input int v);
      if (v <= 0) return TW'(1);
      return v[TW-1:0];
   endfunction

   function automatic logic [2:0] main_of(input state_t s);
      case (s)
         S_MAIN_GREEN:  return GREEN;
         S_MAIN_YELLOW: return YELLOW;
         default:       return RED;
      endcase
   endfunction

   function automatic logic [2:0] side_of(input state_t s);
      case (s)
         S_SIDE_GREEN:  return GREEN;
         S_SIDE_YELLOW: return YELLOW;
         default:       return RED;
      endcase
   endfunction

endpackage

// File: rtl/light_sequencer_phase_guard.sv
// Occupancy counter qualifying timer expiry once a phase is 2+ cycles old.
// Cleared on the edge that issues a timer load.
module light_sequencer_phase_guard (
   input  logic i_clk,
   input  logic i_reset,
   input  logic i_clr,
   input  logic i_timer_out,
   output logic o_expire
);

   logic [1:0] r_cnt;

   always_ff @(posedge i_clk) begin
      if (i_reset || i_clr) begin
         r_cnt <= 2'd0;
      end else if (r_cnt != 2'd3) begin
         r_cnt <= r_cnt + 2'd1;
      end
   end

   assign o_expire = i_timer_out && r_cnt[1];

endmodule

// File: rtl/light_sequencer.sv
// Traffic intersection phase sequencer driving a countdown timer's load port.
// Define LIGHT_SEQ_WALK_EN to build the pedestrian walk phase.
module light_sequencer
   import light_sequencer_pkg::*;
#(
   parameter int T_MAIN_GREEN = 20,
   parameter int T_SIDE_GREEN = 12,
   parameter int T_YELLOW     = 4,
   parameter int T_ALL_RED    = 2,
   parameter int T_WALK       = 10
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          side_sensor,
   input  logic          walk_btn,
   input  logic          timer_out,
   output logic          timer_load,
   output logic [TW-1:0] timer_value,
   output logic [2:0]    main_light,
   output logic [2:0]    side_light,
   output logic          walk_light
);

   if (T_MAIN_GREEN > 127 || T_SIDE_GREEN > 127 || T_YELLOW > 127 ||
       T_ALL_RED > 127 || T_WALK > 127) begin : g_bad_param
      $error("light_sequencer: duration parameter exceeds 127");
   end

   localparam logic [TW-1:0] D_MG = clamp_dur(T_MAIN_GREEN);
   localparam logic [TW-1:0] D_SG = clamp_dur(T_SIDE_GREEN);
   localparam logic [TW-1:0] D_Y  = clamp_dur(T_YELLOW);
   localparam logic [TW-1:0] D_AR = clamp_dur(T_ALL_RED);
   localparam logic [TW-1:0] D_W  = clamp_dur(T_WALK);

   function automatic logic [TW-1:0] dur_of(input state_t s);
      case (s)
         S_MAIN_GREEN:  return D_MG;
         S_MAIN_YELLOW: return D_Y;
         S_ALL_RED_A:   return D_AR;
         S_WALK:        return D_W;
         S_SIDE_GREEN:  return D_SG;
         S_SIDE_YELLOW: return D_Y;
         S_ALL_RED_B:   return D_AR;
         default:       return '0;
      endcase
   endfunction

   state_t        r_state;
   state_t        w_state_nxt;
   logic          w_load_nxt;
   logic          w_expire;
   logic          w_walk_req;
   logic          r_load;
   logic [TW-1:0] r_value;
   logic [2:0]    r_main;
   logic [2:0]    r_side;

   light_sequencer_phase_guard u_guard (
      .i_clk       (clk),
      .i_reset     (reset),
      .i_clr       (w_load_nxt),
      .i_timer_out (timer_out),
      .o_expire    (w_expire)
   );

`ifdef LIGHT_SEQ_WALK_EN
   logic r_walk_req;
   logic r_walk_light;

   // A press on the expiry cycle itself still counts.
   assign w_walk_req = r_walk_req | walk_btn;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_walk_req   <= 1'b0;
         r_walk_light <= 1'b0;
      end else begin
         r_walk_light <= (w_state_nxt == S_WALK);
         if (w_state_nxt == S_WALK && r_state != S_WALK) begin
            r_walk_req <= 1'b0;
         end else if (walk_btn && r_state != S_WALK) begin
            r_walk_req <= 1'b1;
         end
      end
   end

   assign walk_light = r_walk_light;
`else
   logic w_unused_walk;
   assign w_unused_walk = walk_btn;
   assign w_walk_req    = 1'b0;
   assign walk_light    = 1'b0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_load_nxt  = 1'b0;
      case (r_state)
         S_INIT: begin
            w_state_nxt = S_MAIN_GREEN;
            w_load_nxt  = 1'b1;
         end
         S_MAIN_GREEN: begin
            if (w_expire) begin
               w_load_nxt = 1'b1;
               if (side_sensor || w_walk_req) begin
                  w_state_nxt = S_MAIN_YELLOW;
               end
            end
         end
         S_MAIN_YELLOW: begin
            if (w_expire) begin
               w_load_nxt  = 1'b1;
               w_state_nxt = S_ALL_RED_A;
            end
         end
         S_ALL_RED_A: begin
            if (w_expire) begin
               w_load_nxt  = 1'b1;
               w_state_nxt = w_walk_req ? S_WALK : S_SIDE_GREEN;
            end
         end
         S_WALK: begin
            if (w_expire) begin
               w_load_nxt  = 1'b1;
               w_state_nxt = side_sensor ? S_SIDE_GREEN : S_ALL_RED_B;
            end
         end
         S_SIDE_GREEN: begin
            if (w_expire) begin
               w_load_nxt  = 1'b1;
               w_state_nxt = S_SIDE_YELLOW;
            end
         end
         S_SIDE_YELLOW: begin
            if (w_expire) begin
               w_load_nxt  = 1'b1;
               w_state_nxt = S_ALL_RED_B;
            end
         end
         S_ALL_RED_B: begin
            if (w_expire) begin
               w_load_nxt  = 1'b1;
               w_state_nxt = S_MAIN_GREEN;
            end
         end
         default: begin
            w_state_nxt = S_INIT;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_INIT;
         r_load  <= 1'b0;
         r_value <= '0;
         r_main  <= RED;
         r_side  <= RED;
      end else begin
         r_state <= w_state_nxt;
         r_load  <= w_load_nxt;
         r_main  <= main_of(w_state_nxt);
         r_side  <= side_of(w_state_nxt);
         if (w_load_nxt) begin
            r_value <= dur_of(w_state_nxt);
         end
      end
   end

   assign timer_load  = r_load;
   assign timer_value = r_value;
   assign main_light  = r_main;
   assign side_light  = r_side;

endmodule
